// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM states, widths and
// operation codes. Optional feature macro: DIV_FAST_SPECIAL_EN.
package div_ctrl_pkg;

  localparam int DIV_XLEN = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  // Operation select codes shared with the ALU decode.
  localparam logic [4:0] ALU_DIV  = 5'h0C;
  localparam logic [4:0] ALU_DIVU = 5'h0D;
  localparam logic [4:0] ALU_REM  = 5'h0E;
  localparam logic [4:0] ALU_REMU = 5'h0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Magnitude of a value; only two's-complement negative values of signed
  // operations are negated.
  function automatic logic [DIV_XLEN-1:0] abs_val(input logic [DIV_XLEN-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DIV_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring radix-2 division step: shift the dividend MSB into the
// partial remainder, trial-subtract the divisor, shift in the quotient bit.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [DIV_XLEN-1:0] rem_i,
  input  logic [DIV_XLEN-1:0] quo_i,
  input  logic [DIV_XLEN-1:0] dvsr_i,
  output logic [DIV_XLEN-1:0] rem_o,
  output logic [DIV_XLEN-1:0] quo_o
);

  logic [DIV_XLEN:0] shifted;
  logic              fits;

  // Trial subtraction; the difference always fits in DIV_XLEN bits when taken.
  always_comb begin
    shifted = {rem_i, quo_i[DIV_XLEN-1]};
    fits    = (shifted >= {1'b0, dvsr_i});
    rem_o   = fits ? (shifted[DIV_XLEN-1:0] - dvsr_i) : shifted[DIV_XLEN-1:0];
    quo_o   = {quo_i[DIV_XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller (IDLE -> RUN x32 -> DONE).
// Optional feature macro: DIV_FAST_SPECIAL_EN (divide-by-zero and signed
// overflow skip the iterations and finish in one cycle).
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          func,
  input  logic [DIV_XLEN-1:0] opa,
  input  logic [DIV_XLEN-1:0] opb,
  input  logic                kill,
  output logic                busy,
  output logic                done,
  output logic [DIV_XLEN-1:0] result
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_XLEN-1:0] rem_q, rem_d;
  logic [DIV_XLEN-1:0] quo_q, quo_d;
  logic [DIV_XLEN-1:0] dvsr_q, dvsr_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                is_rem_q, is_rem_d;
  logic                dz_q, dz_d;
  logic [DIV_XLEN-1:0] result_q, result_d;
  logic [DIV_XLEN-1:0] prev_q, prev_d;

  logic [DIV_XLEN-1:0] step_rem, step_quo;
  logic                op_signed, op_rem, opa_neg, opb_neg, opb_zero;

  assign op_signed = (func == ALU_DIV) || (func == ALU_REM);
  assign op_rem    = (func == ALU_REM) || (func == ALU_REMU);
  assign opa_neg   = op_signed & opa[DIV_XLEN-1];
  assign opb_neg   = op_signed & opb[DIV_XLEN-1];
  assign opb_zero  = (opb == '0);

`ifdef DIV_FAST_SPECIAL_EN
  logic                special;
  logic [DIV_XLEN-1:0] special_res;
  assign special     = opb_zero | (op_signed & (opa == {1'b1, {(DIV_XLEN-1){1'b0}}}) & (opb == '1));
  assign special_res = opb_zero ? (op_rem ? opa : '1)
                                : (op_rem ? '0 : {1'b1, {(DIV_XLEN-1){1'b0}}});
`endif

  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  assign result = result_q;

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    prev_d    = prev_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          busy      = 1'b1;
          dvsr_d    = abs_val(opb, op_signed);
          quo_d     = abs_val(opa, op_signed);
          rem_d     = '0;
          cnt_d     = CNT_W'(DIV_ITER - 1);
          neg_quo_d = opa_neg ^ opb_neg;
          neg_rem_d = opa_neg;
          is_rem_d  = op_rem;
          dz_d      = opb_zero;
          state_d   = RUN;
`ifdef DIV_FAST_SPECIAL_EN
          if (special) begin
            state_d  = DONE;
            cnt_d    = '0;
            prev_d   = result_q;
            result_d = special_res;
          end
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (kill) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Last step: sign-correct and publish; a zero divisor never negates the quotient.
            state_d  = DONE;
            cnt_d    = '0;
            prev_d   = result_q;
            result_d = is_rem_q ? (neg_rem_q ? -step_rem : step_rem)
                                : ((neg_quo_q & ~dz_q) ? -step_quo : step_quo);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (kill) begin
          // A flushed result is withdrawn so the visible value stays the old one.
          result_d = prev_q;
        end else begin
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      prev_q    <= prev_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed table, randomized ops against an
// arithmetic reference model, kill and reset sequences.
// Honours DIV_FAST_SPECIAL_EN for the expected latency of special cases.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  func = ALU_DIVU;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .opa    (opa),
    .opb    (opb),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic op_is_signed(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_REM);
  endfunction

  function automatic logic op_is_rem(input logic [4:0] f);
    return (f == ALU_REM) || (f == ALU_REMU);
  endfunction

  // Reference: plain integer arithmetic plus the architectural special cases.
  function automatic logic [31:0] ref_model(input logic [4:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op_is_rem(f) ? a : 32'hFFFF_FFFF;
    if (op_is_signed(f)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return op_is_rem(f) ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return op_is_rem(f) ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op_is_rem(f) ? (a % b) : (a / b);
  endfunction

  function automatic int exp_latency(input logic [4:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 32'd0 || (op_is_signed(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 1;
`endif
    return 33;
  endfunction

  // Called just after a rising edge; issues start in that cycle (cycle 0).
  task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int   lat;
    int   exp_lat;
    logic all_busy;
    exp_lat = exp_latency(f, a, b);
    func  = f;
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(negedge clk);
    all_busy = busy;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
      end
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      all_busy = all_busy & busy;
    end
    if (lat == 0) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result, exp);
    check({name, " busy_during"}, {31'd0, all_busy}, 32'd1);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    check({name, " result_hold"}, result, exp);
    $display("op %s f=%h a=%h b=%h result=%h latency=%0d", name, f, a, b, result, lat);
    last_res = exp;
  endtask

  task automatic watch_no_done(input int n, input string name);
    logic any_done;
    any_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    check({name, " no_done"}, {31'd0, any_done}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  codes[4];
    codes[0] = ALU_DIV; codes[1] = ALU_DIVU; codes[2] = ALU_REM; codes[3] = ALU_REMU;

    vecs.push_back('{ALU_DIVU, 32'd100,        32'd7,          32'd14,         "divu_100_7"});
    vecs.push_back('{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"});
    vecs.push_back('{ALU_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_5_0"});
    vecs.push_back('{ALU_REMU, 32'd5,          32'd0,          32'd5,          "remu_5_0"});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  "div_m5_0"});
    vecs.push_back('{ALU_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  "rem_m5_0"});
    vecs.push_back('{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"});
    vecs.push_back('{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf"});
    vecs.push_back('{ALU_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  "div_100_m7"});
    vecs.push_back('{ALU_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          "rem_100_m7"});
    vecs.push_back('{ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "divu_max_1"});
    vecs.push_back('{ALU_REMU, 32'h1234_5678,  32'h0000_0100,  32'h0000_0078,  "remu_hex"});

    // Reset state while rst is held low.
    #2;
    check("reset result", result, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf = codes[$urandom_range(0, 3)];
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      do_op(rf, ra, rb, ref_model(rf, ra, rb), "rand");
    end

    // Kill in cycle 10 of a run.
    func  = ALU_DIVU;
    opa   = 32'd1000;
    opb   = 32'd3;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    check("kill busy_c10", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    check("kill busy_c11", {31'd0, busy}, 32'd0);
    check("kill done_c11", {31'd0, done}, 32'd0);
    check("kill result_kept", result, last_res);
    watch_no_done(40, "kill");
    check("kill result_after", result, last_res);
    $display("seq kill_in_run result=%h", result);

    // Kill and start together in IDLE.
    start = 1'b1;
    kill  = 1'b1;
    func  = ALU_DIVU;
    opa   = 32'd50;
    opb   = 32'd5;
    @(negedge clk);
    check("killstart busy_same", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    @(negedge clk);
    check("killstart busy_next", {31'd0, busy}, 32'd0);
    watch_no_done(40, "killstart");
    $display("seq kill_start_idle result=%h", result);

    // Reset in cycle 15 of a run.
    func  = ALU_DIVU;
    opa   = 32'd77;
    opb   = 32'd5;
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    #1;
    rst = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    last_res = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    watch_no_done(40, "rst");
    $display("seq reset_in_run result=%h", result);
    do_op(ALU_DIVU, 32'd9, 32'd3, 32'd3, "divu_9_3_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The module SHALL expose `clk` (input, 1 bit): the single clock; all state updates on its rising edge.
REQ-002 The module SHALL expose `rst` (input, 1 bit): reset, asynchronous and active-low.
REQ-003 The module SHALL expose `start` (input, 1 bit): request a division; sampled only in IDLE.
REQ-004 The module SHALL expose `func` (input, 5 bits): operation select, one of the `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU` codes from `sys_defs.vh`.
REQ-005 The module SHALL expose `opa` (input, 32 bits): dividend.
REQ-006 The module SHALL expose `opb` (input, 32 bits): divisor.
REQ-007 The module SHALL expose `kill` (input, 1 bit): synchronous abort from pipeline flush.
REQ-008 The module SHALL expose `busy` (output, 1 bit): the EX-stage busy flag that freezes the pipeline while a divide is in progress.
REQ-009 The module SHALL expose `done` (output, 1 bit): result valid, one-cycle pulse.
REQ-010 The module SHALL expose `result` (output, 32 bits): quotient or remainder, registered.

Function
REQ-011 The block SHALL use the states IDLE, RUN and DONE.
REQ-012 IDLE with `start`=1, `kill`=0: the block SHALL capture |opa|, |opb| (absolute values only for signed ops), the sign flags, the op and zero-divisor flag, load the iteration counter to 31, clear the partial remainder, and go to RUN.
REQ-013 RUN SHALL perform one restoring radix-2 step per cycle and decrement the counter; the counter at 0 SHALL go to DONE; exactly 32 steps are performed.
REQ-014 Entering DONE, the block SHALL register `result`: the quotient for DIV/DIVU, the remainder for REM/REMU, after sign correction.
REQ-015 Sign correction: the quotient SHALL be negated iff the op is signed, sign(opa)≠sign(opb) and opb≠0; the remainder SHALL be negated iff the op is signed and opa is negative.
REQ-016 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder = opa, for signed and unsigned ops.
REQ-017 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient 0x80000000 and remainder 0.
REQ-018 `busy` SHALL be combinational: 1 when (IDLE & `start` & ~`kill`) or RUN; 0 in DONE and otherwise.
REQ-019 DONE SHALL last exactly one cycle with `done`=1, then go to IDLE; `start` SHALL be ignored in DONE.
REQ-020 `result` SHALL hold its value until the next DONE.
REQ-021 Latency: with `start` in cycle 0, `done` SHALL assert in cycle 33 and `busy` SHALL be high in cycles 0-32.
REQ-022 `kill` in RUN or DONE SHALL force IDLE on the next edge with no `done` and `result` unchanged.
REQ-023 `kill` and `start` asserted together in IDLE: kill SHALL win and no operation starts.
REQ-024 Operands SHALL be sampled only at start; changes to `opa`/`opb` during RUN SHALL have no effect.

Reset
REQ-025 Reset asserted SHALL immediately force state=IDLE, counter=0, internal registers=0, `result`=0, `done`=0, and `busy`=0 when `start` is low.
REQ-026 Reset mid-RUN SHALL abandon the operation with no `done` after release.

Configuration
REQ-027 The block SHALL support the macro `DIV_FAST_SPECIAL_EN`. When defined, divide-by-zero and signed overflow SHALL go IDLE→DONE directly with the REQ-016/017 values, `done` in cycle 1, and `busy` high in cycle 0 only.
REQ-028 When `DIV_FAST_SPECIAL_EN` is undefined, these cases SHALL run the full 32 iterations and produce identical values via REQ-015.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/RUN/DONE), `DIV_XLEN`=32 and `DIV_ITER`=32.
REQ-030 The datapath SHALL use the sub-module `div_step`: one combinational restoring step (shift, trial subtract, quotient bit), instantiated once.

Verification
REQ-031 The bench SHALL check: DIVU 100/7, start at cycle 0 → `done` in cycle 33, `result`=14, `busy` high cycles 0-32.
REQ-032 The bench SHALL check: REM 0xFFFFFFF9 (-7) / 2 → `result`=0xFFFFFFFF (-1); DIV with the same operands → 0xFFFFFFFD (-3).
REQ-033 The bench SHALL check: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0xFFFFFFFB/0 → 0xFFFFFFFF, in both macro builds with the REQ-027/028 latency.
REQ-034 The bench SHALL check: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
REQ-035 The bench SHALL check: `kill` in cycle 10 of RUN → `busy`=0 in cycle 11, no `done`, `result` keeps its prior value; `kill`+`start` together in IDLE → no `busy` after that cycle.
REQ-036 The bench SHALL check: `rst` low in cycle 15 of RUN → IDLE immediately, `result`=0, and the next DIVU 9/3 returns 3 normally.
